// File: rtl/id_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_pkg                                                               |
// | Opcodes, exe_cmd encoding, instruction field positions and opcode decoder. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package id_stage_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int SRC1_MSB = 25;
  localparam int SRC1_LSB = 21;
  localparam int REG2_MSB = 20;
  localparam int REG2_LSB = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd3;
  localparam logic [3:0] CMD_OR  = 4'd4;
  localparam logic [3:0] CMD_NOR = 4'd5;
  localparam logic [3:0] CMD_XOR = 4'd6;
  localparam logic [3:0] CMD_SLA = 4'd7;
  localparam logic [3:0] CMD_SLL = 4'd8;
  localparam logic [3:0] CMD_SRA = 4'd9;
  localparam logic [3:0] CMD_SRL = 4'd10;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_REG2 = 2'd2
  } dest_sel_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_e;

  typedef struct packed {
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       use_src1;
    logic       use_reg2;
    logic       imm_sel;
    logic       st_sel;
    dest_sel_e  dest_sel;
    br_e        br;
  } dec_t;

  // Opcode-only decode; anything unrecognised stays an all-zero NOP.
  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d          = '0;
    d.dest_sel = DEST_NONE;
    d.br       = BR_NONE;
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: d.cmd = CMD_ADD;
      OP_SUB, OP_SUBI:               d.cmd = CMD_SUB;
      OP_AND:                        d.cmd = CMD_AND;
      OP_OR:                         d.cmd = CMD_OR;
      OP_NOR:                        d.cmd = CMD_NOR;
      OP_XOR:                        d.cmd = CMD_XOR;
      OP_SLA:                        d.cmd = CMD_SLA;
      OP_SLL:                        d.cmd = CMD_SLL;
      OP_SRA:                        d.cmd = CMD_SRA;
      OP_SRL:                        d.cmd = CMD_SRL;
      default:                       d.cmd = CMD_NOP;
    endcase
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
      OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        d.wb_en    = 1'b1;
        d.use_src1 = 1'b1;
        d.use_reg2 = 1'b1;
        d.dest_sel = DEST_RD;
      end
      OP_ADDI, OP_SUBI: begin
        d.wb_en    = 1'b1;
        d.use_src1 = 1'b1;
        d.imm_sel  = 1'b1;
        d.dest_sel = DEST_REG2;
      end
      OP_LD: begin
        d.wb_en    = 1'b1;
        d.mem_r_en = 1'b1;
        d.use_src1 = 1'b1;
        d.imm_sel  = 1'b1;
        d.dest_sel = DEST_REG2;
      end
      OP_ST: begin
        d.mem_w_en = 1'b1;
        d.use_src1 = 1'b1;
        d.use_reg2 = 1'b1;
        d.imm_sel  = 1'b1;
        d.st_sel   = 1'b1;
      end
      OP_BEZ: begin
        d.use_src1 = 1'b1;
        d.br       = BR_BEZ;
      end
      OP_BNE: begin
        d.use_src1 = 1'b1;
        d.use_reg2 = 1'b1;
        d.br       = BR_BNE;
      end
      OP_JMP:  d.br = BR_JMP;
      OP_NOP:  d.br = BR_NONE;
      default: d.br = BR_NONE;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_register_file                                                     |
// | 32x32 register file, two async read ports, one write port, write-through.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_stage_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];
  logic        w_wr_live;

  assign w_wr_live = i_we && (i_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // A write in flight is visible to a same-cycle read of that register.
  always_comb begin
    if (i_raddr1 == 5'd0) begin
      o_rdata1 = '0;
    end else if (w_wr_live && (i_raddr1 == i_waddr)) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
  end

  always_comb begin
    if (i_raddr2 == 5'd0) begin
      o_rdata2 = '0;
    end else if (w_wr_live && (i_raddr2 == i_waddr)) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage                                                                   |
// | Decode stage: IF/ID latch, register file, decode, hazards, branch, ID/EX.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        superStall,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [4:0]  exe_dest,
  input  logic [4:0]  mem_dest,
  input  logic        exe_wb_en,
  input  logic        mem_wb_en,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [31:0] id_pc,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] st_val,
  output logic [4:0]  dest,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en
);

  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;

  logic [31:0] r_id_pc;
  logic [31:0] r_val1;
  logic [31:0] r_val2;
  logic [31:0] r_st_val;
  logic [4:0]  r_dest;
  logic [3:0]  r_exe_cmd;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic        r_wb_en;

  logic [5:0]  w_opcode;
  logic [4:0]  w_src1;
  logic [4:0]  w_reg2;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_imm_sext;
  dec_t        w_dec;
  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;
  logic        w_hz_src1;
  logic        w_hz_reg2;
  logic        w_stall;
  logic        w_branch_cond;
  logic        w_branch_taken;
  logic [31:0] w_branch_target;
  logic [31:0] w_val2;
  logic [31:0] w_st_val;
  logic [4:0]  w_dest;

  assign w_opcode   = r_ifid_instr[OPC_MSB:OPC_LSB];
  assign w_src1     = r_ifid_instr[SRC1_MSB:SRC1_LSB];
  assign w_reg2     = r_ifid_instr[REG2_MSB:REG2_LSB];
  assign w_rd       = r_ifid_instr[RD_MSB:RD_LSB];
  assign w_imm      = r_ifid_instr[IMM_MSB:IMM_LSB];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_dec      = decode_op(w_opcode);

  id_stage_register_file u_register_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_en_in),
    .i_waddr  (wb_dest),
    .i_wdata  (wb_data),
    .i_raddr1 (w_src1),
    .i_raddr2 (w_reg2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // No forwarding: any in-flight writer of a consumed source forces a stall.
  assign w_hz_src1 = w_dec.use_src1 && (w_src1 != 5'd0) &&
                     ((exe_wb_en && (w_src1 == exe_dest)) ||
                      (mem_wb_en && (w_src1 == mem_dest)));
  assign w_hz_reg2 = w_dec.use_reg2 && (w_reg2 != 5'd0) &&
                     ((exe_wb_en && (w_reg2 == exe_dest)) ||
                      (mem_wb_en && (w_reg2 == mem_dest)));
  assign w_stall   = w_hz_src1 || w_hz_reg2;

  always_comb begin
    case (w_dec.br)
      BR_BEZ:  w_branch_cond = (w_rdata1 == 32'd0);
      BR_BNE:  w_branch_cond = (w_rdata1 != w_rdata2);
      BR_JMP:  w_branch_cond = 1'b1;
      default: w_branch_cond = 1'b0;
    endcase
  end

  assign w_branch_taken  = !w_stall && !superStall && w_branch_cond;
  assign w_branch_target = r_ifid_pc + 32'd4 + (w_imm_sext << 2);

  always_comb begin
    case (w_dec.dest_sel)
      DEST_RD:   w_dest = w_rd;
      DEST_REG2: w_dest = w_reg2;
      default:   w_dest = 5'd0;
    endcase
  end

  assign w_val2   = w_dec.imm_sel ? w_imm_sext : w_rdata2;
  assign w_st_val = w_dec.st_sel  ? w_rdata2   : 32'd0;

  // IF/ID: a taken branch flushes the wrong-path fetch as fetch redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (w_branch_taken) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= if_pc;
    end else if (!(w_stall || superStall)) begin
      r_ifid_instr <= if_instruction;
      r_ifid_pc    <= if_pc;
    end
  end

  // ID/EX: a hazard stall squashes only the side-effecting controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_val1     <= '0;
      r_val2     <= '0;
      r_st_val   <= '0;
      r_dest     <= '0;
      r_exe_cmd  <= CMD_NOP;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_wb_en    <= 1'b0;
    end else if (!superStall) begin
      r_id_pc  <= r_ifid_pc;
      r_val1   <= w_rdata1;
      r_val2   <= w_val2;
      r_st_val <= w_st_val;
      r_dest   <= w_dest;
      if (w_stall) begin
        r_exe_cmd  <= CMD_NOP;
        r_mem_r_en <= 1'b0;
        r_mem_w_en <= 1'b0;
        r_wb_en    <= 1'b0;
      end else begin
        r_exe_cmd  <= w_dec.cmd;
        r_mem_r_en <= w_dec.mem_r_en;
        r_mem_w_en <= w_dec.mem_w_en;
        r_wb_en    <= w_dec.wb_en;
      end
    end
  end

  assign stall          = w_stall;
  assign branch_taken   = w_branch_taken;
  assign branch_address = w_branch_taken ? w_branch_target : 32'd0;
  assign id_pc          = r_id_pc;
  assign val1           = r_val1;
  assign val2           = r_val2;
  assign st_val         = r_st_val;
  assign dest           = r_dest;
  assign exe_cmd        = r_exe_cmd;
  assign mem_r_en       = r_mem_r_en;
  assign mem_w_en       = r_mem_w_en;
  assign wb_en          = r_wb_en;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_stage                                                                |
// | Directed and random stimulus against a cycle-level model of the ID stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, superStall;
  logic [31:0] if_instruction, if_pc;
  logic        wb_en_in;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [4:0]  exe_dest, mem_dest;
  logic        exe_wb_en, mem_wb_en;
  logic        stall, branch_taken;
  logic [31:0] branch_address, id_pc, val1, val2, st_val;
  logic [4:0]  dest;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en;

  id_stage dut (
    .clk(clk), .rst(rst), .superStall(superStall),
    .if_instruction(if_instruction), .if_pc(if_pc),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_data(wb_data),
    .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .stall(stall), .branch_taken(branch_taken), .branch_address(branch_address),
    .id_pc(id_pc), .val1(val1), .val2(val2), .st_val(st_val), .dest(dest),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state: architectural registers, the IF/ID latch, the ID/EX record.
  typedef struct {
    logic [31:0] pc, v1, v2, st;
    logic [4:0]  dst;
    logic [3:0]  cmd;
    logic        rd, wr, wb;
    bit          k_pc, k_v1, k_v2, k_dst, k_st;
  } ex_t;

  logic [31:0] m_reg [32];
  logic [31:0] m_ifid_instr, m_ifid_pc;
  bit          m_ifid_pc_k;
  bit          m_valid = 0;
  ex_t         m_ex, m_nx;
  bit          m_stall, m_bt;

  function automatic bit is_r(input int op);
    return op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
  endfunction

  function automatic logic [3:0] cmd_of(input int op);
    case (op)
      1, 32, 36, 37: return 4'd1;
      3, 33:         return 4'd2;
      5:  return 4'd3;
      6:  return 4'd4;
      7:  return 4'd5;
      8:  return 4'd6;
      9:  return 4'd7;
      10: return 4'd8;
      11: return 4'd9;
      12: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en_in && wb_dest == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_hz(input logic [4:0] a);
    return (a != 5'd0) && ((exe_wb_en && a == exe_dest) || (mem_wb_en && a == mem_dest));
  endfunction

  // Evaluate the current cycle: check DUT outputs, then work out the next ID/EX record.
  task automatic model_eval();
    int op;
    logic [4:0]  s1, r2, rdf;
    logic [31:0] imm, v1, v2r, tgt;
    bit used1, used2;
    op  = int'(m_ifid_instr[31:26]);
    s1  = m_ifid_instr[25:21];
    r2  = m_ifid_instr[20:16];
    rdf = m_ifid_instr[15:11];
    imm = {{16{m_ifid_instr[15]}}, m_ifid_instr[15:0]};
    used1 = is_r(op) || (op inside {32, 33, 36, 37, 40, 41});
    used2 = is_r(op) || op == 37 || op == 41;
    m_stall = (used1 && m_hz(s1)) || (used2 && m_hz(r2));
    v1  = m_read(s1);
    v2r = m_read(r2);
    m_bt = !m_stall && !superStall &&
           ((op == 40 && v1 == 0) || (op == 41 && v1 != v2r) || op == 42);
    tgt = m_ifid_pc + 32'd4 + imm * 4;

    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
    if (m_bt && m_ifid_pc_k) chk("branch_address", branch_address, tgt);
    chk("exe_cmd", {28'd0, exe_cmd}, {28'd0, m_ex.cmd});
    chk("wb_en", {31'd0, wb_en}, {31'd0, m_ex.wb});
    chk("mem_r_en", {31'd0, mem_r_en}, {31'd0, m_ex.rd});
    chk("mem_w_en", {31'd0, mem_w_en}, {31'd0, m_ex.wr});
    if (m_ex.k_pc)  chk("id_pc", id_pc, m_ex.pc);
    if (m_ex.k_v1)  chk("val1", val1, m_ex.v1);
    if (m_ex.k_v2)  chk("val2", val2, m_ex.v2);
    if (m_ex.k_dst) chk("dest", {27'd0, dest}, {27'd0, m_ex.dst});
    if (m_ex.k_st)  chk("st_val", st_val, m_ex.st);

    m_nx = m_ex;
    if (!superStall && m_stall) begin
      m_nx.cmd = 0; m_nx.rd = 0; m_nx.wr = 0; m_nx.wb = 0;
      m_nx.k_pc = 0; m_nx.k_v1 = 0; m_nx.k_v2 = 0; m_nx.k_dst = 0; m_nx.k_st = 0;
    end else if (!superStall) begin
      m_nx.cmd   = cmd_of(op);
      m_nx.wb    = is_r(op) || (op inside {32, 33, 36});
      m_nx.rd    = (op == 36);
      m_nx.wr    = (op == 37);
      m_nx.pc    = m_ifid_pc;  m_nx.k_pc  = m_ifid_pc_k;
      m_nx.v1    = v1;         m_nx.k_v1  = 1;
      m_nx.v2    = (op inside {32, 33, 36, 37}) ? imm : v2r;
      m_nx.k_v2  = is_r(op) || (op inside {32, 33, 36, 37});
      m_nx.dst   = is_r(op) ? rdf : r2;
      m_nx.k_dst = is_r(op) || (op inside {32, 33, 36});
      m_nx.st    = v2r;        m_nx.k_st  = (op == 37);
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 32'd0;
      m_ifid_instr = 0; m_ifid_pc = 0; m_ifid_pc_k = 1;
      m_ex = '{pc: 0, v1: 0, v2: 0, st: 0, dst: 0, cmd: 0, rd: 0, wr: 0, wb: 0,
               k_pc: 1, k_v1: 1, k_v2: 1, k_dst: 1, k_st: 1};
      m_valid = 1;
    end else if (m_valid) begin
      if (wb_en_in && wb_dest != 0) m_reg[wb_dest] = wb_data;
      m_ex = m_nx;
      if (m_bt) begin
        m_ifid_instr = 0; m_ifid_pc_k = 0;
      end else if (!(m_stall || superStall)) begin
        m_ifid_instr = if_instruction; m_ifid_pc = if_pc; m_ifid_pc_k = 1;
      end
    end
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic cycle();
    #1;
    if (m_valid) model_eval();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rtype(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {op[5:0], rs[4:0], rt[4:0], imm};
  endfunction

  int ops [20] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 2, 63};

  initial begin
    rst = 1; superStall = 0; if_instruction = 0; if_pc = 0;
    wb_en_in = 0; wb_dest = 0; wb_data = 0;
    exe_dest = 0; mem_dest = 0; exe_wb_en = 0; mem_wb_en = 0;
    cycle(); cycle();
    rst = 0;
    #1;
    chk("rst_exe_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("rst_val1", val1, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_branch_address", branch_address, 32'd0);

    // ADDI r1,r0,1546 then ADD r2,r0,r1 behind an EXE/MEM hazard on r1
    if_instruction = itype(32, 0, 1, 16'd1546); if_pc = 32'h0; cycle();
    if_instruction = rtype(1, 0, 1, 2); if_pc = 32'h4; cycle();
    chk("addi_cmd", {28'd0, exe_cmd}, 32'd1);
    chk("addi_val2", val2, 32'd1546);
    chk("addi_dest", {27'd0, dest}, 32'd1);
    exe_dest = 1; exe_wb_en = 1;
    #1 chk("raw_exe_stall", {31'd0, stall}, 32'd1);
    cycle();
    chk("bubble_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("bubble_wb", {31'd0, wb_en}, 32'd0);
    exe_wb_en = 0; mem_dest = 1; mem_wb_en = 1;
    #1 chk("raw_mem_stall", {31'd0, stall}, 32'd1);
    cycle();
    mem_wb_en = 0; wb_en_in = 1; wb_dest = 1; wb_data = 1546; cycle();
    wb_en_in = 0;
    chk("add_val2", val2, 32'd1546);
    chk("add_dest", {27'd0, dest}, 32'd2);

    // BNE r1,r3,-15 at 0xC0 with R1=3, R3=1, then with R3=3
    if_instruction = 0;
    wb_en_in = 1; wb_dest = 1; wb_data = 3; cycle();
    wb_dest = 3; wb_data = 1; cycle();
    wb_en_in = 0;
    if_instruction = itype(41, 1, 3, 16'hFFF1); if_pc = 32'hC0; cycle();
    if_instruction = itype(32, 0, 4, 16'd7); if_pc = 32'hC4;
    #1;
    chk("bne_taken", {31'd0, branch_taken}, 32'd1);
    chk("bne_address", branch_address, 32'h88);
    cycle();
    if_instruction = 0; cycle();
    chk("flush_cmd", {28'd0, exe_cmd}, 32'd0);
    chk("flush_wb", {31'd0, wb_en}, 32'd0);
    wb_en_in = 1; wb_dest = 3; wb_data = 3; cycle();
    wb_en_in = 0;
    if_instruction = itype(41, 1, 3, 16'hFFF1); if_pc = 32'hC0; cycle();
    if_instruction = 0;
    #1 chk("bne_not_taken", {31'd0, branch_taken}, 32'd0);
    cycle();

    // Write-through on R5 while XOR r7,r5,r1 decodes; R0 write ignored
    if_instruction = rtype(8, 5, 1, 7); if_pc = 32'h100; cycle();
    if_instruction = rtype(1, 0, 0, 8);
    wb_en_in = 1; wb_dest = 5; wb_data = 1546; cycle();
    chk("wt_val1", val1, 32'd1546);
    wb_dest = 0; wb_data = 32'hFFFF; cycle();
    wb_en_in = 0; cycle();
    chk("r0_val1", val1, 32'd0);

    // JMP -1 frozen under superStall for 3 cycles
    if_instruction = itype(42, 0, 0, 16'hFFFF); if_pc = 32'h200; cycle();
    superStall = 1; if_instruction = rtype(1, 2, 3, 4); if_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1 chk("ss_branch_taken", {31'd0, branch_taken}, 32'd0);
      cycle();
    end
    superStall = 0;
    #1;
    chk("jmp_taken", {31'd0, branch_taken}, 32'd1);
    chk("jmp_address", branch_address, 32'h200);
    cycle();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int op;
      op = ops[$urandom_range(0, 19)];
      rst        = ($urandom_range(0, 199) == 0);
      superStall = ($urandom_range(0, 9) == 0);
      if (op >= 32 && op != 63)
        if_instruction = itype(op, $urandom_range(0, 7), $urandom_range(0, 7),
                               ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3)));
      else
        if_instruction = rtype(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if_pc     = $urandom & 32'hFFFF_FFFC;
      wb_en_in  = ($urandom_range(0, 1) == 1);
      wb_dest   = 5'($urandom_range(0, 7));
      wb_data   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      exe_dest  = 5'($urandom_range(0, 7));
      mem_dest  = 5'($urandom_range(0, 7));
      exe_wb_en = ($urandom_range(0, 3) == 0);
      mem_wb_en = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
